// File: rtl/semaforo_pedestre_param.sv
// Pedestrian-crossing traffic-light controller with parametrised phase
// durations, N request buttons, minimum vehicle green, all-red clearance,
// flashing pedestrian green and a flashing-amber night mode.
module semaforo_pedestre_param #(
  parameter int N_BOTOES    = 2,
  parameter int T_MIN_VERDE = 20,
  parameter int T_AMARELO   = 4,
  parameter int T_SEGURANCA = 2,
  parameter int T_PED       = 10,
  parameter int T_PISCA     = 6,
  parameter int T_NOTURNO   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BOTOES-1:0] botao_pedestre,
  input  logic                modo_noturno,
  output logic                carro_verde,
  output logic                carro_amarelo,
  output logic                carro_vermelho,
  output logic                ped_verde,
  output logic                ped_vermelho,
  output logic                pedido_pendente,
  output logic [2:0]          estado
);

  // Counter must hold the largest phase length minus one.
  localparam int M1   = (T_MIN_VERDE > T_AMARELO) ? T_MIN_VERDE : T_AMARELO;
  localparam int M2   = (M1 > T_SEGURANCA) ? M1 : T_SEGURANCA;
  localparam int M3   = (M2 > T_PED) ? M2 : T_PED;
  localparam int M4   = (M3 > T_PISCA) ? M3 : T_PISCA;
  localparam int TMAX = (M4 > T_NOTURNO) ? M4 : T_NOTURNO;
  localparam int CW   = $clog2(TMAX) + 1;

  localparam logic [CW-1:0] C_MIN_VERDE = CW'(T_MIN_VERDE - 1);
  localparam logic [CW-1:0] C_AMARELO   = CW'(T_AMARELO - 1);
  localparam logic [CW-1:0] C_SEGURANCA = CW'(T_SEGURANCA - 1);
  localparam logic [CW-1:0] C_PED       = CW'(T_PED - 1);
  localparam logic [CW-1:0] C_PISCA     = CW'(T_PISCA - 1);
  localparam logic [CW-1:0] C_NOTURNO   = CW'(T_NOTURNO - 1);

  typedef enum logic [2:0] {
    VERDE_CARRO = 3'd0,
    AMARELO     = 3'd1,
    SEGURANCA   = 3'd2,
    VERDE_PED   = 3'd3,
    PISCA_PED   = 3'd4,
    NOTURNO     = 3'd5
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic            latch;
  logic            phase;
  logic            press;
  logic            can_latch;

  assign press     = |botao_pedestre;
  assign can_latch = (state == VERDE_CARRO) || (state == AMARELO) ||
                     (state == SEGURANCA);

  // State, phase counter, request latch and night-flash phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= VERDE_CARRO;
      cnt   <= '0;
      latch <= 1'b0;
      phase <= 1'b0;
    end else begin
      state <= state_next;

      if (state_next != state) begin
        cnt <= '0;
      end else if (state == VERDE_CARRO) begin
        // Saturate so the minimum-green condition stays met while idle.
        if (cnt != C_MIN_VERDE) cnt <= cnt + CW'(1);
      end else if (state == NOTURNO && cnt == C_NOTURNO) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (state != NOTURNO && state_next == NOTURNO) begin
        phase <= 1'b1;
      end else if (state == NOTURNO && cnt == C_NOTURNO) begin
        phase <= ~phase;
      end

      // Serving the crossing or going to night mode discards the request;
      // this wins over a press on the same edge so one press is one service.
      if ((state != VERDE_PED && state_next == VERDE_PED) ||
          state_next == NOTURNO) begin
        latch <= 1'b0;
      end else if (press && can_latch) begin
        latch <= 1'b1;
      end
    end
  end

  // Next-state selection; night mode beats a pending request in green.
  always_comb begin
    state_next = state;
    case (state)
      VERDE_CARRO: begin
        if (modo_noturno)                      state_next = NOTURNO;
        else if (latch && cnt == C_MIN_VERDE)  state_next = AMARELO;
      end
      AMARELO:   if (cnt == C_AMARELO)   state_next = SEGURANCA;
      SEGURANCA: if (cnt == C_SEGURANCA) state_next = VERDE_PED;
      VERDE_PED: if (cnt == C_PED)       state_next = PISCA_PED;
      PISCA_PED: if (cnt == C_PISCA)     state_next = VERDE_CARRO;
      NOTURNO:   if (!modo_noturno)      state_next = VERDE_CARRO;
      default:                           state_next = VERDE_CARRO;
    endcase
  end

  // Moore lamp decode from registered state, counter and phase only.
  always_comb begin
    carro_verde    = 1'b0;
    carro_amarelo  = 1'b0;
    carro_vermelho = 1'b0;
    ped_verde      = 1'b0;
    ped_vermelho   = 1'b0;
    case (state)
      VERDE_CARRO: begin carro_verde    = 1'b1; ped_vermelho = 1'b1; end
      AMARELO:     begin carro_amarelo  = 1'b1; ped_vermelho = 1'b1; end
      SEGURANCA:   begin carro_vermelho = 1'b1; ped_vermelho = 1'b1; end
      VERDE_PED:   begin carro_vermelho = 1'b1; ped_verde    = 1'b1; end
      PISCA_PED:   begin carro_vermelho = 1'b1; ped_verde    = ~cnt[0]; end
      NOTURNO:     carro_amarelo = phase;
      default:     begin carro_verde    = 1'b1; ped_vermelho = 1'b1; end
    endcase
  end

  assign pedido_pendente = latch;
  assign estado          = state;

endmodule

// File: doc/semaforo_pedestre_param.md
# semaforo_pedestre_param

Parametrised pedestrian-crossing traffic-light controller, successor to the fixed-timing pedestrian semaphore. It serves N request buttons, enforces a minimum vehicle-green time and an all-red clearance interval, and flashes the pedestrian green before it ends. A night mode flashes the vehicle amber. All phase durations are parameters counted in `clk` cycles; it sits between debounced push-button inputs and the lamp drivers.

## Interface
Parameters:
- `N_BOTOES`, 2: number of pedestrian request buttons (≥1).
- `T_MIN_VERDE`, 20: minimum vehicle-green cycles before a request is served (≥1).
- `T_AMARELO`, 4: vehicle-amber cycles (≥1).
- `T_SEGURANCA`, 2: all-red clearance cycles (≥1).
- `T_PED`, 10: steady pedestrian-green cycles (≥1).
- `T_PISCA`, 6: flashing pedestrian-green cycles (≥1).
- `T_NOTURNO`, 8: night-mode amber half-period in cycles (≥1).

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `botao_pedestre`  in  N_BOTOES: request buttons, synchronous to `clk`, active-high.
- `modo_noturno`  in  1: night-mode request, level-sensitive.
- `carro_verde`, `carro_amarelo`, `carro_vermelho`  out  1 each: vehicle lamps.
- `ped_verde`, `ped_vermelho`  out  1 each: pedestrian lamps.
- `pedido_pendente`  out  1: latched request flag.
- `estado`  out  3: current state code.

## Operation
- States and codes: VERDE_CARRO=0, AMARELO=1, SEGURANCA=2, VERDE_PED=3, PISCA_PED=4, NOTURNO=5.
- Counter `cnt`: cleared to 0 on every state transition and increments by 1 each cycle. Width is $clog2(max of all T parameters)+1. It never wraps, except in NOTURNO.
- Request latch: `pedido_pendente` is set on an edge where OR(`botao_pedestre`)=1 and the state is VERDE_CARRO, AMARELO or SEGURANCA. It clears on the edge that enters VERDE_PED. Presses in VERDE_PED, PISCA_PED and NOTURNO are ignored.
- VERDE_CARRO:
  - `cnt` saturates at T_MIN_VERDE-1.
  - Go to AMARELO when `pedido_pendente`=1 and `cnt`=T_MIN_VERDE-1.
  - Go to NOTURNO when `modo_noturno`=1. Night mode has priority over a pending request.
  - Otherwise stay indefinitely.
- AMARELO → SEGURANCA → VERDE_PED → PISCA_PED → VERDE_CARRO. Each transition happens when `cnt` = that state's T-1, so each state lasts exactly its T cycles. `modo_noturno` does not abort this sequence.
- NOTURNO:
  - A phase bit is set to 1 on entry and toggles each time `cnt`=T_NOTURNO-1; `cnt` then returns to 0.
  - Go to VERDE_CARRO when `modo_noturno`=0. `pedido_pendente` is forced to 0 throughout.
- Lamp decode (Moore: a function of the state, `cnt` and phase registers only; no input-to-output path):
  - VERDE_CARRO: carro_verde=1, ped_vermelho=1.
  - AMARELO: carro_amarelo=1, ped_vermelho=1.
  - SEGURANCA: carro_vermelho=1, ped_vermelho=1.
  - VERDE_PED: carro_vermelho=1, ped_verde=1.
  - PISCA_PED: carro_vermelho=1, ped_verde = ~cnt[0].
  - NOTURNO: carro_amarelo = phase; all other lamps 0.
  - Every lamp not listed for a state is 0.
- Reset:
  - Asserting `rst` immediately forces state VERDE_CARRO, `cnt`=0, latch=0 and phase=0, with no clock edge needed.
  - Outputs are then carro_verde=1, ped_vermelho=1, all other lamps 0, `pedido_pendente`=0, `estado`=0.
  - Deassertion is synchronous-safe. The first counted cycle is the first rising edge after release.

## Timing
- A press sampled at edge k sets `pedido_pendente` after edge k. If the minimum green is already met, `estado`=1 after edge k+1; otherwise AMARELO follows the edge where `cnt` reaches T_MIN_VERDE-1.
- A press asserted and deasserted between two edges is not seen.
- Full serviced cycle length: T_AMARELO+T_SEGURANCA+T_PED+T_PISCA cycles from AMARELO entry to VERDE_CARRO re-entry.
- On re-entry to VERDE_CARRO, the minimum-green timer restarts. A press during the return is not latched until VERDE_CARRO is entered.
- Simultaneous press and `modo_noturno`=1 in VERDE_CARRO: enter NOTURNO and clear the latch.
- Night exit: `modo_noturno` falls at edge k → `estado`=0 after edge k+1.

## Test plan
Parameters for all scenarios: N_BOTOES=2, T_MIN_VERDE=4, T_AMARELO=2, T_SEGURANCA=1, T_PED=3, T_PISCA=4, T_NOTURNO=2.
1. Reset, then 50 idle cycles → carro_verde=1, ped_vermelho=1, `estado`=0 throughout, `pedido_pendente`=0.
2. One-cycle pulse on botao[1] at idle cycle 10 → latch=1 next edge, AMARELO the edge after. States then last 2/1/3/4 cycles, `ped_verde` in PISCA_PED reads 1,0,1,0, then `estado`=0 and latch=0.
3. Press on the first cycle after reset release → AMARELO entered only after 4 green cycles.
4. Press during AMARELO → no second service cycle. Press during VERDE_PED → ignored, latch stays 0 after return.
5. `modo_noturno`=1 asserted mid-VERDE_PED → sequence completes, one VERDE_CARRO cycle, then NOTURNO. Amber reads 1,1,0,0,1,1… and presses are ignored. Deassert → VERDE_CARRO with latch 0.
6. `rst` pulsed mid-AMARELO between clock edges → reset output values appear immediately, then normal operation resumes after release.
